pwm_gate_ctrl: RTL and testbench

Parametrised PWM output gate for the CPLD. It sits between the DSP PWM pins and the gate-driver pins, and holds all N_CH gate outputs low until a power-up delay has expired. It adds a software enable with a re-arm delay, a filtered latching fault trip, optional shoot-through detection on complementary pairs, and a saturating trip counter. It replaces the fixed 10-channel power-up delay gate.

---
 rtl/pwm_gate_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pwm_gate_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gate_ctrl.sv
// pwm_gate_ctrl: gates N_CH PWM lines to the gate drivers behind a power-up delay,
// a software enable with re-arm delay, a filtered latching fault trip and a shoot-through kill.
module pwm_gate_ctrl #(
  parameter int N_CH         = 10,
  parameter int DELAY_CYCLES = 15000000,
  parameter int REARM_CYCLES = 50000,
  parameter int CNT_W        = 24,
  parameter int FLT_FILT     = 8,
  parameter int PAIR_CHK     = 1
) (
  input  logic            CLK_50M,
  input  logic            Rst,
  input  logic [N_CH-1:0] pwm_in,
  input  logic            en_req,
  input  logic            fault_in,
  input  logic            clr_fault,
  output logic [N_CH-1:0] pwm_out,
  output logic [2:0]      state,
  output logic            fault_latched,
  output logic            st_err,
  output logic [7:0]      trip_cnt
);

  localparam int N_PAIR = ((N_CH / 2) > 0) ? (N_CH / 2) : 1;
  localparam int FW     = $clog2(FLT_FILT + 1);

  localparam logic [CNT_W-1:0] LP_DLY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ARM_LAST = CNT_W'(REARM_CYCLES - 1);
  localparam logic [FW-1:0]    LP_FLT_SAT  = FW'(FLT_FILT);

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ARM     = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_gate_en;
  logic              r_fault_latched;
  logic [7:0]        r_trip_cnt;
  logic              r_flt_p0;
  logic              r_flt_p1;
  logic [FW-1:0]     r_flt_cnt;
  logic              r_st_evt;
  logic              r_st_err;

  logic [N_PAIR-1:0] w_pair_st;
  logic [N_CH-1:0]   w_st_kill;
  logic              w_st_any;
  logic              w_flt_ok;
  logic              w_clr_ok;
  logic              w_enter_flt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  function automatic logic [FW-1:0] flt_step(input logic hi, input logic [FW-1:0] c);
    if (!hi)
      return '0;
    else if (c == LP_FLT_SAT)
      return c;
    else
      return c + FW'(1);
  endfunction

  // Complementary pair check: both legs high kills the pair in the same cycle
  generate
    if (PAIR_CHK != 0) begin : g_pair
      for (genvar k = 0; k < N_CH / 2; k++) begin : g_k
        assign w_pair_st[k]       = pwm_in[2*k] & pwm_in[2*k+1];
        assign w_st_kill[2*k]     = w_pair_st[k];
        assign w_st_kill[2*k+1]   = w_pair_st[k];
      end
    end else begin : g_nopair
      assign w_pair_st = '0;
      assign w_st_kill = '0;
    end
  endgenerate

  assign w_st_any = |w_pair_st;
  assign w_flt_ok = (r_flt_cnt == LP_FLT_SAT);

  assign pwm_out       = pwm_in & {N_CH{r_gate_en}} & ~w_st_kill;
  assign state         = r_state;
  assign fault_latched = r_fault_latched;
  assign st_err        = r_st_err;
  assign trip_cnt      = r_trip_cnt;

  // Stage p0/p1: fault_in synchroniser, then the run-length filter
  always_ff @(posedge CLK_50M or posedge Rst) begin
    if (Rst) begin
      r_flt_p0  <= 1'b0;
      r_flt_p1  <= 1'b0;
      r_flt_cnt <= '0;
    end else begin
      r_flt_p0  <= fault_in;
      r_flt_p1  <= r_flt_p0;
      r_flt_cnt <= flt_step(r_flt_p1, r_flt_cnt);
    end
  end

  assign w_enter_flt = (r_state != ST_FAULT) && (w_flt_ok || r_st_evt);
  assign w_clr_ok    = (r_state == ST_FAULT) && clr_fault && !w_flt_ok
                       && !w_st_any && !r_st_evt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_POWERUP: if (r_cnt == LP_DLY_LAST) w_state_nxt = en_req ? ST_RUN : ST_IDLE;
      ST_IDLE:    if (en_req) w_state_nxt = ST_ARM;
      ST_ARM: begin
        if (!en_req)
          w_state_nxt = ST_IDLE;
        else if (r_cnt == LP_ARM_LAST)
          w_state_nxt = ST_RUN;
      end
      ST_RUN:     if (!en_req) w_state_nxt = ST_IDLE;
      ST_FAULT:   if (w_clr_ok) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_POWERUP;
    endcase
    if (w_enter_flt)
      w_state_nxt = ST_FAULT;
  end

  always_ff @(posedge CLK_50M or posedge Rst) begin
    if (Rst)
      r_state <= ST_POWERUP;
    else
      r_state <= w_state_nxt;
  end

  // Delay counter restarts on every state change; only POWERUP and ARM count
  always_ff @(posedge CLK_50M or posedge Rst) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == ST_POWERUP) || (r_state == ST_ARM)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_50M or posedge Rst) begin
    if (Rst) begin
      r_gate_en       <= 1'b0;
      r_fault_latched <= 1'b0;
      r_trip_cnt      <= '0;
    end else begin
      r_gate_en       <= (w_state_nxt == ST_RUN);
      r_fault_latched <= (w_state_nxt == ST_FAULT);
      if (w_enter_flt)
        r_trip_cnt <= sat_inc8(r_trip_cnt);
    end
  end

  // Stage p1: registered shoot-through event feeds the FSM as an unfiltered trip
  always_ff @(posedge CLK_50M or posedge Rst) begin
    if (Rst) begin
      r_st_evt <= 1'b0;
      r_st_err <= 1'b0;
    end else begin
      r_st_evt <= w_st_any;
      if (w_st_any)
        r_st_err <= 1'b1;
      else if (w_clr_ok)
        r_st_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_gate_ctrl.sv
// Self-checking bench for pwm_gate_ctrl with N_CH=4, DELAY_CYCLES=100, REARM_CYCLES=20,
// FLT_FILT=4, PAIR_CHK=1; inputs change and outputs are sampled around the falling edge.
module tb_pwm_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pwm_in;
  logic       en_req;
  logic       fault_in;
  logic       clr_fault;
  logic [3:0] pwm_out;
  logic [2:0] state;
  logic       fault_latched;
  logic       st_err;
  logic [7:0] trip_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [3:0] pwm;
    logic [2:0] st;
  } exp_t;

  typedef struct packed {
    logic [3:0] pwm_in;
    logic       en;
    logic [3:0] exp_pwm;
    logic [2:0] exp_st;
  } vec_t;

  exp_t  sb_q[$];
  string sb_nm[$];
  vec_t  vecs[9];

  pwm_gate_ctrl #(
    .N_CH(4), .DELAY_CYCLES(100), .REARM_CYCLES(20), .CNT_W(8), .FLT_FILT(4), .PAIR_CHK(1)
  ) dut (
    .CLK_50M(clk), .Rst(rst), .pwm_in(pwm_in), .en_req(en_req), .fault_in(fault_in),
    .clr_fault(clr_fault), .pwm_out(pwm_out), .state(state), .fault_latched(fault_latched),
    .st_err(st_err), .trip_cnt(trip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic sb_push(input string nm, input logic [3:0] p, input logic [2:0] s);
    exp_t e;
    e.pwm = p;
    e.st  = s;
    sb_q.push_back(e);
    sb_nm.push_back(nm);
  endtask

  task automatic sb_check();
    exp_t  e;
    string nm;
    while (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      nm = sb_nm.pop_front();
      chk({nm, "_pwm"},   32'(pwm_out), 32'(e.pwm));
      chk({nm, "_state"}, 32'(state),   32'(e.st));
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the falling edge right after reset release
  task automatic pwrup_check(input string nm);
    pwm_in = 4'b1010;
    for (int k = 0; k <= 102; k++) begin
      sb_push(nm, (k >= 100) ? pwm_in : 4'b0000, (k >= 100) ? 3'd3 : 3'd0);
      #1 sb_check();
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
  endtask

  initial begin
    vecs[0] = '{4'b0000, 1'b1, 4'b0000, 3'd3};
    vecs[1] = '{4'b0001, 1'b1, 4'b0001, 3'd3};
    vecs[2] = '{4'b0010, 1'b1, 4'b0010, 3'd3};
    vecs[3] = '{4'b0100, 1'b1, 4'b0100, 3'd3};
    vecs[4] = '{4'b1000, 1'b1, 4'b1000, 3'd3};
    vecs[5] = '{4'b1001, 1'b1, 4'b1001, 3'd3};
    vecs[6] = '{4'b0110, 1'b1, 4'b0110, 3'd3};
    vecs[7] = '{4'b0101, 1'b1, 4'b0101, 3'd3};
    vecs[8] = '{4'b1010, 1'b1, 4'b1010, 3'd3};

    rst       = 1'b1;
    pwm_in    = 4'b0101;
    en_req    = 1'b1;
    fault_in  = 1'b0;
    clr_fault = 1'b0;
    nclk(3);
    sb_push("reset", 4'b0000, 3'd0);
    #1 sb_check();
    chk("reset_flt_latched", 32'(fault_latched), 0);
    chk("reset_st_err",      32'(st_err),        0);
    chk("reset_trip_cnt",    32'(trip_cnt),      0);

    // Power-up hold-off
    @(negedge clk);
    rst = 1'b0;
    pwrup_check("pwrup1");

    // Combinational gating in RUN
    for (int i = 0; i < 9; i++) begin
      pwm_in = vecs[i].pwm_in;
      en_req = vecs[i].en;
      sb_push($sformatf("vec%0d", i), vecs[i].exp_pwm, vecs[i].exp_st);
      #1 sb_check();
      nclk(1);
    end

    // Enable drop and re-arm
    en_req = 1'b0;
    pwm_in = 4'b1010;
    sb_push("en_drop_same", 4'b1010, 3'd3);
    #1 sb_check();
    nclk(1);
    sb_push("en_drop_next", 4'b0000, 3'd1);
    #1 sb_check();
    en_req = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      nclk(1);
      sb_push($sformatf("rearm%0d", j), (j <= 20) ? 4'b0000 : 4'b1010, (j <= 20) ? 3'd2 : 3'd3);
      #1 sb_check();
    end

    // 3-cycle fault glitch must not trip
    fault_in = 1'b1;
    nclk(3);
    fault_in = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      nclk(1);
      sb_push($sformatf("glitch%0d", j), 4'b1010, 3'd3);
      #1 sb_check();
    end

    // Sustained fault trips 7 edges after the rise
    fault_in = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      nclk(1);
      sb_push($sformatf("flt_lat%0d", j), (j < 7) ? 4'b1010 : 4'b0000, (j < 7) ? 3'd3 : 3'd4);
      #1 sb_check();
    end
    chk("flt_trip_cnt", 32'(trip_cnt),      1);
    chk("flt_latched",  32'(fault_latched), 1);
    nclk(1);
    clr_fault = 1'b1;
    nclk(1);
    clr_fault = 1'b0;
    sb_push("clr_ignored", 4'b0000, 3'd4);
    #1 sb_check();
    nclk(1);
    fault_in = 1'b0;
    nclk(4);
    sb_push("flt_hold", 4'b0000, 3'd4);
    #1 sb_check();
    clr_fault = 1'b1;
    nclk(1);
    clr_fault = 1'b0;
    sb_push("flt_clr", 4'b0000, 3'd1);
    #1 sb_check();
    chk("flt_clr_latched", 32'(fault_latched), 0);
    chk("flt_clr_trip",    32'(trip_cnt),      1);
    nclk(25);
    sb_push("rearm2", 4'b1010, 3'd3);
    #1 sb_check();

    // Shoot-through on pair 0 while pair 1 keeps passing
    pwm_in = 4'b1011;
    sb_push("st_kill", 4'b1000, 3'd3);
    #1 sb_check();
    nclk(1);
    chk("st_err_set", 32'(st_err), 1);
    pwm_in = 4'b1000;
    sb_push("st_evt", 4'b1000, 3'd3);
    #1 sb_check();
    nclk(1);
    sb_push("st_fault", 4'b0000, 3'd4);
    #1 sb_check();
    chk("st_trip_cnt", 32'(trip_cnt),      2);
    chk("st_latched",  32'(fault_latched), 1);
    pwm_in    = 4'b0011;
    clr_fault = 1'b1;
    nclk(1);
    sb_push("st_clr_block", 4'b0000, 3'd4);
    #1 sb_check();
    chk("st_err_hold", 32'(st_err), 1);
    pwm_in    = 4'b0000;
    clr_fault = 1'b0;
    nclk(1);
    clr_fault = 1'b1;
    nclk(1);
    clr_fault = 1'b0;
    en_req    = 1'b0;
    sb_push("st_clr", 4'b0000, 3'd1);
    #1 sb_check();
    chk("st_err_clr",  32'(st_err),   0);
    chk("st_clr_trip", 32'(trip_cnt), 2);

    // Trip counter saturation
    for (int i = 0; i < 260; i++) begin
      pwm_in = 4'b0011;
      nclk(1);
      pwm_in = 4'b0000;
      nclk(1);
      clr_fault = 1'b1;
      nclk(1);
      clr_fault = 1'b0;
      if (i == 250)
        chk("trip_pre_sat", 32'(trip_cnt), 253);
    end
    chk("trip_sat", 32'(trip_cnt), 255);
    sb_push("sat_idle", 4'b0000, 3'd1);
    #1 sb_check();

    // Reset mid-ARM at cnt=10, then full power-up delay again
    en_req = 1'b1;
    pwm_in = 4'b1010;
    nclk(11);
    sb_push("arm_cnt10", 4'b0000, 3'd2);
    #1 sb_check();
    rst = 1'b1;
    #1;
    sb_push("rst_arm", 4'b0000, 3'd0);
    sb_check();
    chk("rst_arm_trip", 32'(trip_cnt), 0);
    nclk(2);
    rst = 1'b0;
    pwrup_check("pwrup2");

    // Reset mid-RUN kills outputs immediately
    #2 rst = 1'b1;
    #1;
    sb_push("rst_run", 4'b0000, 3'd0);
    sb_check();
    chk("rst_run_st_err",  32'(st_err),        0);
    chk("rst_run_latched", 32'(fault_latched), 0);
    @(negedge clk);
    rst = 1'b0;
    nclk(3);
    sb_push("rst_run_hold", 4'b0000, 3'd0);
    #1 sb_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
